// File: rtl/multicycle_controller.sv
`default_nettype none
// multicycle_controller: fetch/decode/exec/mem/wb sequencer for a shared-port multi-cycle RV32I core.
// Revision 1.0 - initial release
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  op,
  input  logic        take_branch,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6,
    S_UNUSED = 3'd7
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam logic [1:0] PCSRC_PLUS4 = 2'b00;
  localparam logic [1:0] PCSRC_IMM   = 2'b01;
  localparam logic [1:0] PCSRC_ALU   = 2'b10;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

  state_t           cur_state;
  state_t           nxt_state;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       cause_nxt;
  logic             retire;
  logic             legal_op;
  logic             is_load;
  logic             is_store;
  logic             is_branch;
  logic             timed_out;

  assign state = cur_state;

  always_comb begin
    legal_op = 1'b0;
    case (op)
      OP_LOAD, OP_ALUI, OP_AUIPC, OP_STORE, OP_LUI,
      OP_ALU, OP_BRANCH, OP_JALR, OP_JAL: legal_op = 1'b1;
      default:                            legal_op = 1'b0;
    endcase
  end

  assign is_load   = (op == OP_LOAD);
  assign is_store  = (op == OP_STORE);
  assign is_branch = (op == OP_BRANCH);

  // A ready response in the same cycle always wins over the timeout.
  assign timed_out = (wait_cnt == TIMEOUT_CNT) && !mem_ready;

  always_comb begin
    nxt_state = cur_state;
    cause_nxt = trap_cause;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    adr_src   = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PCSRC_PLUS4;
    reg_write = 1'b0;
    retire    = 1'b0;

    case (cur_state)
      S_RST: begin
        nxt_state = S_FETCH;
      end

      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          nxt_state = S_DECODE;
        end else if (timed_out) begin
          nxt_state = S_TRAP;
          cause_nxt = CAUSE_TIMEOUT;
        end
      end

      S_DECODE: begin
        if (legal_op) begin
          nxt_state = S_EXEC;
        end else begin
          nxt_state = S_TRAP;
          cause_nxt = CAUSE_ILLEGAL;
        end
      end

      S_EXEC: begin
        if (!legal_op) begin
          nxt_state = S_TRAP;
          cause_nxt = CAUSE_ILLEGAL;
        end else if (is_branch) begin
          pc_write  = 1'b1;
          pc_src    = take_branch ? PCSRC_IMM : PCSRC_PLUS4;
          retire    = 1'b1;
          nxt_state = S_FETCH;
        end else if (is_load || is_store) begin
          nxt_state = S_MEM;
        end else begin
          nxt_state = S_WB;
        end
      end

      S_MEM: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        mem_we  = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_write  = 1'b1;
            retire    = 1'b1;
            nxt_state = S_FETCH;
          end else begin
            nxt_state = S_WB;
          end
        end else if (timed_out) begin
          nxt_state = S_TRAP;
          cause_nxt = CAUSE_TIMEOUT;
        end
      end

      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        retire    = 1'b1;
        if (op == OP_JAL) begin
          pc_src = PCSRC_IMM;
        end else if (op == OP_JALR) begin
          pc_src = PCSRC_ALU;
        end
        nxt_state = S_FETCH;
      end

      S_TRAP: begin
        nxt_state = S_TRAP;
      end

      default: begin
        nxt_state = S_TRAP;
        cause_nxt = CAUSE_ILLEGAL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state  <= S_RST;
      trap       <= 1'b0;
      trap_cause <= CAUSE_NONE;
      instret    <= 32'd0;
    end else begin
      cur_state  <= nxt_state;
      trap       <= (nxt_state == S_TRAP);
      trap_cause <= cause_nxt;
      if (retire) begin
        instret <= instret + 32'd1;
      end
    end
  end

  // Any state change (including entry to FETCH or MEM) restarts the wait count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (mem_ready || (nxt_state != cur_state)) begin
      wait_cnt <= '0;
    end else if ((cur_state == S_FETCH) || (cur_state == S_MEM)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// tb_multicycle_controller: randomized directed bench with a per-instruction timing model.
// Revision 1.0 - initial release
module tb_multicycle_controller;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  op = 7'b0110011;
  logic        take_branch = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic        adr_src;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        reg_write;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [2:0]  state;
  logic [31:0] instret;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_instret = 32'd0;

  logic [6:0] legal_ops [9] = '{7'b0000011, 7'b0010011, 7'b0010111, 7'b0100011,
                                7'b0110111, 7'b0110011, 7'b1100011, 7'b1100111, 7'b1101111};

  multicycle_controller #(.MEM_TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .op(op), .take_branch(take_branch), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .trap(trap),
    .trap_cause(trap_cause), .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, then releases into RST.
  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_strobes", {28'd0, ir_write, pc_write, reg_write, mem_we}, 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_trap", {29'd0, trap, trap_cause}, 32'd0);
    exp_instret = 32'd0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_one_cycle", 32'(state), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Runs one legal instruction starting in FETCH: fw wait cycles on fetch, mw on the data access.
  task automatic run_instr(input logic [6:0] o, input logic t, input int fw, input int mw);
    int  exp_st[$];
    bit  ldst, st, br;
    int  n_ir, n_pc, n_reg, n_req, n_adr, n_we, st_err, ir_idx, pc_idx;
    logic [1:0] src_seen, src_exp;
    ldst = (o == 7'b0000011) || (o == 7'b0100011);
    st   = (o == 7'b0100011);
    br   = (o == 7'b1100011);
    for (int i = 0; i <= fw; i++) exp_st.push_back(1);
    exp_st.push_back(2);
    exp_st.push_back(3);
    if (ldst) for (int i = 0; i <= mw; i++) exp_st.push_back(4);
    if (!br && !st) exp_st.push_back(5);
    if (br) src_exp = t ? 2'b01 : 2'b00;
    else if (o == 7'b1101111) src_exp = 2'b01;
    else if (o == 7'b1100111) src_exp = 2'b10;
    else src_exp = 2'b00;

    n_ir = 0; n_pc = 0; n_reg = 0; n_req = 0; n_adr = 0; n_we = 0; st_err = 0;
    ir_idx = -1; pc_idx = -1; src_seen = 2'b11;
    op = o;
    take_branch = t;
    for (int c = 0; c < exp_st.size(); c++) begin
      if (c == fw || (ldst && c == fw + 3 + mw)) mem_ready = 1'b1;
      else if (exp_st[c] == 1 || exp_st[c] == 4) mem_ready = 1'b0;
      else mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (state !== 3'(exp_st[c])) st_err++;
      if (ir_write) begin n_ir++; ir_idx = c; end
      if (pc_write) begin n_pc++; pc_idx = c; src_seen = pc_src; end
      if (reg_write) n_reg++;
      if (mem_req) n_req++;
      if (mem_req && adr_src) n_adr++;
      if (mem_we) n_we++;
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    if (!(st && mw > 0) || ldst || !ldst) exp_instret = exp_instret + 32'd1;
    check($sformatf("state_seq op=%b", o), 32'(st_err), 32'd0);
    check("ir_write_count", 32'(n_ir), 32'd1);
    check("ir_write_cycle", 32'(ir_idx), 32'(fw));
    check("pc_write_count", 32'(n_pc), 32'd1);
    check("pc_write_cycle", 32'(pc_idx), 32'(exp_st.size() - 1));
    check($sformatf("pc_src op=%b tb=%0d", o, t), 32'(src_seen), 32'(src_exp));
    check("reg_write_count", 32'(n_reg), (br || st) ? 32'd0 : 32'd1);
    check("mem_req_cycles", 32'(n_req), 32'(fw + 1 + (ldst ? mw + 1 : 0)));
    check("adr_src_cycles", 32'(n_adr), ldst ? 32'(mw + 1) : 32'd0);
    check("mem_we_cycles", 32'(n_we), st ? 32'(mw + 1) : 32'd0);
    check("back_in_fetch", 32'(state), 32'd1);
    check("instret", instret, exp_instret);
  endtask

  initial begin
    int n, errs;
    #3;
    do_reset();

    // Directed: add, taken/not-taken beq, stalled lw, sw, jal, jalr
    run_instr(7'b0110011, 1'b0, 0, 0);
    run_instr(7'b1100011, 1'b1, 0, 0);
    run_instr(7'b1100011, 1'b0, 0, 0);
    run_instr(7'b0000011, 1'b0, 0, 3);
    run_instr(7'b0100011, 1'b0, 0, 0);
    run_instr(7'b1101111, 1'b0, 1, 0);
    run_instr(7'b1100111, 1'b0, 0, 0);
    run_instr(7'b0100011, 1'b1, TMO, TMO);

    for (int k = 0; k < 40; k++) begin
      run_instr(legal_ops[$urandom_range(0, 8)], 1'($urandom_range(0, 1)),
                int'($urandom_range(0, TMO)), int'($urandom_range(0, TMO)));
    end

    // Illegal opcode traps after DECODE and stays there
    op = 7'b1111111;
    mem_ready = 1'b1;
    @(negedge clk);
    check("illegal_fetch_state", 32'(state), 32'd1);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    check("illegal_decode_state", 32'(state), 32'd2);
    @(posedge clk); #1;
    check("illegal_trap_state", 32'(state), 32'd6);
    check("illegal_trap", 32'(trap), 32'd1);
    check("illegal_cause", 32'(trap_cause), 32'd1);
    check("illegal_instret", instret, exp_instret);
    errs = 0;
    for (int i = 0; i < 8; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (mem_req !== 1'b0 || state !== 3'd6 || trap_cause !== 2'b01 ||
          {ir_write, pc_write, reg_write, mem_we} !== 4'b0) errs++;
      @(posedge clk); #1;
    end
    check("trap_sticky", 32'(errs), 32'd0);
    check("trap_instret", instret, exp_instret);

    // Fetch timeout: counter 0..TMO without ready, then TRAP cause 10
    do_reset();
    n = 0;
    mem_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (state !== 3'd1) break;
      n++;
      @(posedge clk); #1;
    end
    check("fetch_timeout_cycles", 32'(n), 32'(TMO + 1));
    check("fetch_timeout_state", 32'(state), 32'd6);
    check("fetch_timeout_cause", 32'(trap_cause), 32'd2);
    check("fetch_timeout_mem_req", 32'(mem_req), 32'd0);

    // Memory-phase timeout on a load
    do_reset();
    run_instr(7'b0010011, 1'b0, 0, 0);
    op = 7'b0000011;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (state !== 3'd4) break;
      n++;
      @(posedge clk); #1;
    end
    check("mem_timeout_cycles", 32'(n), 32'(TMO + 1));
    check("mem_timeout_cause", 32'(trap_cause), 32'd2);
    check("mem_timeout_instret", instret, exp_instret);

    // Reset mid-stall in FETCH after retiring one instruction
    do_reset();
    run_instr(7'b0110111, 1'b0, 0, 0);
    mem_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #2;
    do_reset();
    run_instr(7'b0010111, 1'b0, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
FSM sequencer for a multi-cycle RV32I core that shares one instruction/data memory port. It steps each instruction through fetch, decode, execute, memory and writeback. It emits the datapath strobes for IR load, PC update, register write and memory requests. The main decoder still produces the static per-opcode controls; this block only handles timing, memory-wait handshaking, timeout trapping and retired-instruction counting.

Parameters:
MEM_TIMEOUT, 255, max wait cycles on a memory request before trapping (1..2^CNT_W-1)
CNT_W, 8, width of wait counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous active-high reset
op  in  7  opcode field of the IR (valid from DECODE onward)
take_branch  in  1  branch resolution from main decoder, sampled in EXEC
mem_ready  in  1  memory handshake completion; ignored while mem_req=0
mem_req  out  1  memory request; held with adr_src/mem_we stable until mem_ready
mem_we  out  1  write strobe qualifying mem_req (stores only)
adr_src  out  1  0=PC address, 1=ALU result address
ir_write  out  1  load IR from memory read data this edge
pc_write  out  1  update PC this edge
pc_src  out  2  00=PC+4, 01=PC+imm (branch taken/jal), 10=ALU result with bit0 cleared (jalr)
reg_write  out  1  register file write this edge
trap  out  1  sticky halt indicator
trap_cause  out  2  00=none, 01=illegal opcode, 10=memory timeout
state  out  3  current state encoding, for debug
instret  out  32  retired instruction count

Behaviour:
- States: RST=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6; 7 is unreachable and goes to TRAP with cause 01.
- Reset asserted (asynchronous): state=RST; instret=0; wait counter=0; trap=0; trap_cause=00.
- While in RST, every strobe output is 0.
- RST -> FETCH unconditionally after one cycle.
- mem_req, mem_we, adr_src and state are Moore outputs. ir_write, pc_write, pc_src and reg_write are Mealy outputs qualified as listed below. Outside the listed cases, all strobes are 0 and pc_src=00.
- FETCH: mem_req=1, adr_src=0.
  - On mem_ready=1 at the edge: ir_write=1, go to DECODE.
  - Otherwise stay in FETCH and increment the wait counter.
- DECODE: takes 1 cycle.
  - Legal opcodes: 0000011, 0010011, 0010111, 0100011, 0110111, 0110011, 1100011, 1100111, 1101111. These go to EXEC.
  - Any other opcode goes to TRAP with cause 01.
- EXEC, branch (1100011): pc_write=1; pc_src=01 if take_branch, else 00; instret+1; go to FETCH.
- EXEC, load/store: go to MEM.
- EXEC, all other legal opcodes: go to WB.
- MEM: mem_req=1, adr_src=1, mem_we=1 only for store.
  - Load with mem_ready: go to WB.
  - Store with mem_ready: pc_write=1, pc_src=00, instret+1, go to FETCH.
  - No mem_ready: stay and increment the wait counter.
- WB: reg_write=1, pc_write=1; instret+1; go to FETCH.
  - pc_src=01 for jal, 10 for jalr, 00 otherwise.
- Wait counter:
  - Cleared on entry to FETCH and to MEM.
  - Also cleared on any cycle where mem_ready=1.
  - When the counter reaches MEM_TIMEOUT with mem_ready still 0, the next state is TRAP with cause 10, and mem_req drops.
- Zero-wait memory (mem_ready high in the same cycle as the request) completes in one cycle.
- Cycles per instruction with zero-wait memory: ALU/lui/auipc/jal/jalr = 4, load = 5, store = 4, branch = 3.
- TRAP: all strobes 0, trap=1, trap_cause holds its value; only reset leaves TRAP.
- instret wraps from 0xFFFFFFFF to 0 and never saturates.
- A new mem_ready arriving with mem_req=0 has no effect.
- Reset during MEM or FETCH: mem_req drops immediately (asynchronously); no strobe is emitted.

Test Plan:
- Reset, then zero-wait memory, one add (0110011) -> state sequence 0,1,2,3,5,1; one cycle each of ir_write, reg_write and pc_write (pc_src=00); instret=1.
- Taken beq: take_branch=1 in EXEC -> pc_write with pc_src=01, no reg_write, back in FETCH 3 cycles after fetch completes.
- Not-taken beq gives pc_src=00 under the same timing.
- lw with mem_ready delayed 3 cycles in MEM -> mem_req=1 and adr_src=1 held for 4 cycles, mem_we=0, then WB with reg_write; 8 cycles total; instret+1.
- sw -> mem_we=1 with mem_req in MEM, pc_write on completion, reg_write never asserted.
- op=1111111 -> TRAP after DECODE, trap=1, trap_cause=01, no further mem_req until reset, instret unchanged.
- MEM_TIMEOUT=4 with mem_ready held 0 in FETCH -> TRAP entered after 5 FETCH cycles, cause 10.
- Asserting reset mid-stall clears everything and restarts at RST.
